// File: rtl/llc_line_adaptor_pkg.sv
// rtl/llc_line_adaptor_pkg.sv - shared types for the cache line to memory burst adaptor
package llc_line_adaptor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DONE,
    WR,
    WR_DONE
  } state_t;

  localparam int LLC_BEATS = 4;

endpackage

// File: rtl/llc_line_adaptor_beat_buffer.sv
// rtl/llc_line_adaptor_beat_buffer.sv - line register with whole-line load, per-beat write and per-beat read mux
module llc_line_adaptor_beat_buffer #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [LINE_W-1:0] load_line,
  input  logic              beat_en,
  input  logic [CNT_W-1:0]  beat_idx,
  input  logic [BEAT_W-1:0] beat_data,
  output logic [LINE_W-1:0] line,
  output logic [BEAT_W-1:0] beat
);

  logic [LINE_W-1:0] line_q;

  // A whole-line load only happens in IDLE and beat writes only in RD, so priority never matters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
    end else if (load_en) begin
      line_q <= load_line;
    end else if (beat_en) begin
      line_q[beat_idx*BEAT_W +: BEAT_W] <= beat_data;
    end
  end

  assign line = line_q;
  assign beat = line_q[beat_idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/llc_line_adaptor.sv
// rtl/llc_line_adaptor.sv - converts one cache line read/write into a fixed beat burst; LLC_ADAPTOR_RD_BYPASS_EN completes reads on the final beat
module llc_line_adaptor
  import llc_line_adaptor_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic              read_o,
  output logic              write_o,
  output logic [ADDR_W-1:0] address_o,
  output logic [BEAT_W-1:0] burst_o,
  input  logic [BEAT_W-1:0] burst_i,
  input  logic              resp_i
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] buf_line, rd_line_q, rd_fin_line;
  logic [BEAT_W-1:0] buf_beat;
  logic              last_beat, load_en, beat_en, rd_fin;
  logic              addr_unused;

  assign addr_unused = ^address_i[OFF_W-1:0];
  assign last_beat   = resp_i && (cnt == CNT_W'(BEATS - 1));
  assign beat_en     = (state == RD) && resp_i;
  assign rd_fin_line = {burst_i, buf_line[LINE_W-BEAT_W-1:0]};

  llc_line_adaptor_beat_buffer #(
    .LINE_W(LINE_W),
    .BEAT_W(BEAT_W),
    .CNT_W (CNT_W)
  ) u_buffer (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .load_line(line_i),
    .beat_en  (beat_en),
    .beat_idx (cnt),
    .beat_data(burst_i),
    .line     (buf_line),
    .beat     (buf_beat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      rd_line_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (read_i || write_i)) begin
        addr_q <= {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end
      if ((state == RD || state == WR) && resp_i) begin
        cnt <= last_beat ? '0 : cnt + 1'b1;
      end
      // Captured whole on the final beat so line_o never exposes a partially filled line.
      if (rd_fin) begin
        rd_line_q <= rd_fin_line;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    load_en   = 1'b0;
    rd_fin    = 1'b0;
    resp_o    = 1'b0;
    read_o    = 1'b0;
    write_o   = 1'b0;
    address_o = '0;
    burst_o   = '0;
    case (state)
      IDLE: begin
        if (write_i) begin
          load_en  = 1'b1;
          state_nx = WR;
        end else if (read_i) begin
          state_nx = RD;
        end
      end
      RD: begin
        read_o    = 1'b1;
        address_o = addr_q;
        if (last_beat) begin
          rd_fin = 1'b1;
`ifdef LLC_ADAPTOR_RD_BYPASS_EN
          resp_o   = 1'b1;
          state_nx = IDLE;
`else
          state_nx = RD_DONE;
`endif
        end
      end
      RD_DONE: begin
        resp_o   = 1'b1;
        state_nx = IDLE;
      end
      WR: begin
        write_o   = 1'b1;
        address_o = addr_q;
        burst_o   = buf_beat;
        if (last_beat) begin
          state_nx = WR_DONE;
        end
      end
      WR_DONE: begin
        resp_o   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef LLC_ADAPTOR_RD_BYPASS_EN
  assign line_o = rd_fin ? rd_fin_line : rd_line_q;
`else
  assign line_o = rd_line_q;
`endif

endmodule
